// File: rtl/axis_round_divider.sv
// Sequential signed divider: Q = A / B, one quotient bit per clock, convergent rounding
// of the magnitude, saturation to A_WIDTH bits and a fixed divide-by-zero result.
module axis_round_divider #(
    parameter int unsigned A_WIDTH = 16,
    parameter int unsigned B_WIDTH = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [A_WIDTH+B_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [A_WIDTH-1:0]         m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready
);

    localparam int unsigned CNT_W = $clog2(A_WIDTH + 1);
    localparam int unsigned R_W   = B_WIDTH + 1;
    localparam int unsigned S_W   = A_WIDTH + 1;
    localparam logic [A_WIDTH-1:0] POS_MAX = {1'b0, {(A_WIDTH-1){1'b1}}};
    localparam logic [A_WIDTH-1:0] NEG_MIN = {1'b1, {(A_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // a_q starts as |A| and fills with quotient bits from the LSB as dividend bits shift out
    logic [A_WIDTH-1:0] a_q, a_nxt;
    logic [B_WIDTH-1:0] b_q, b_nxt;
    logic [R_W-1:0]     rem_q, rem_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               sign_q, sign_nxt;
    logic               a_neg_q, a_neg_nxt;
    logic               b_zero_q, b_zero_nxt;
    logic [A_WIDTH-1:0] tdata_nxt;
    logic               tvalid_nxt;
    logic               tready_nxt;

    logic [A_WIDTH-1:0] a_in, a_abs;
    logic [B_WIDTH-1:0] b_in, b_abs;
    logic               accept;
    logic               calc_last;
    logic [R_W-1:0]     rem_shift, rem_step, b_ext;
    logic               sub_ok;
    logic [B_WIDTH+1:0] rem_dbl, b_cmp;
    logic               round_up;
    logic [S_W-1:0]     mag, sres;
    logic [A_WIDTH-1:0] sat, result;

    assign a_in  = s_axis_tdata[A_WIDTH-1:0];
    assign b_in  = s_axis_tdata[A_WIDTH+B_WIDTH-1:A_WIDTH];
    assign a_abs = a_in[A_WIDTH-1] ? (~a_in + A_WIDTH'(1)) : a_in;
    assign b_abs = b_in[B_WIDTH-1] ? (~b_in + B_WIDTH'(1)) : b_in;

    assign accept = (state == IDLE) && s_axis_tready && s_axis_tvalid;
    // CALC runs A_WIDTH step cycles plus one cycle that retires the counter
    assign calc_last = (cnt_q == CNT_W'(A_WIDTH));

    // Restoring division step
    assign b_ext     = {1'b0, b_q};
    assign rem_shift = {rem_q[B_WIDTH-1:0], a_q[A_WIDTH-1]};
    assign sub_ok    = (rem_shift >= b_ext);
    assign rem_step  = sub_ok ? (rem_shift - b_ext) : rem_shift;

    // Round half to even on the magnitude, then apply sign and saturate
    assign rem_dbl  = {rem_q, 1'b0};
    assign b_cmp    = {2'b00, b_q};
    assign round_up = (rem_dbl > b_cmp) || ((rem_dbl == b_cmp) && a_q[0]);
    assign mag      = {1'b0, a_q} + S_W'(round_up);
    assign sres     = sign_q ? (~mag + S_W'(1)) : mag;
    assign sat      = (sres[S_W-1] != sres[S_W-2]) ? (sres[S_W-1] ? NEG_MIN : POS_MAX)
                                                   : sres[A_WIDTH-1:0];
    assign result   = b_zero_q ? (a_neg_q ? NEG_MIN : POS_MAX) : sat;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = CALC;
            CALC:    if (calc_last)     state_nxt = ROUND;
            ROUND:                      state_nxt = DONE;
            DONE:    if (m_axis_tready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_nxt      = a_q;
        b_nxt      = b_q;
        rem_nxt    = rem_q;
        cnt_nxt    = cnt_q;
        sign_nxt   = sign_q;
        a_neg_nxt  = a_neg_q;
        b_zero_nxt = b_zero_q;
        tdata_nxt  = m_axis_tdata;
        tvalid_nxt = m_axis_tvalid;
        tready_nxt = (state_nxt == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    a_nxt      = a_abs;
                    b_nxt      = b_abs;
                    rem_nxt    = '0;
                    cnt_nxt    = '0;
                    sign_nxt   = a_in[A_WIDTH-1] ^ b_in[B_WIDTH-1];
                    a_neg_nxt  = a_in[A_WIDTH-1];
                    b_zero_nxt = (b_in == '0);
                end
            end
            CALC: begin
                if (calc_last) begin
                    cnt_nxt = '0;
                end else begin
                    rem_nxt = rem_step;
                    a_nxt   = {a_q[A_WIDTH-2:0], sub_ok};
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ROUND: begin
                tdata_nxt  = result;
                tvalid_nxt = 1'b1;
            end
            DONE: begin
                if (m_axis_tready) tvalid_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_q           <= '0;
            b_q           <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            sign_q        <= 1'b0;
            a_neg_q       <= 1'b0;
            b_zero_q      <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            a_q           <= a_nxt;
            b_q           <= b_nxt;
            rem_q         <= rem_nxt;
            cnt_q         <= cnt_nxt;
            sign_q        <= sign_nxt;
            a_neg_q       <= a_neg_nxt;
            b_zero_q      <= b_zero_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tvalid <= tvalid_nxt;
            s_axis_tready <= tready_nxt;
        end
    end

endmodule

// File: tb/tb_axis_round_divider.sv
// Bench for axis_round_divider: directed corner cases, backpressure, mid-operation
// reset and randomized streaming against an arithmetic reference model.
module tb_axis_round_divider;

    localparam int unsigned AW     = 16;
    localparam int unsigned BW     = 16;
    localparam int          N_RAND = 1500;

    logic          aclk;
    logic          aresetn;
    logic [AW+BW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [AW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];

    axis_round_divider #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division of magnitudes, round half to even, then sign and clamp
    function automatic logic [15:0] ref_div(input int a, input int b);
        longint aa, bb, q, r, s;
        if (b == 0) return (a < 0) ? 16'h8000 : 16'h7fff;
        aa = (a < 0) ? -longint'(a) : longint'(a);
        bb = (b < 0) ? -longint'(b) : longint'(b);
        q  = aa / bb;
        r  = aa % bb;
        if ((2 * r > bb) || ((2 * r == bb) && (q % 2 == 1))) q++;
        s = ((a < 0) != (b < 0)) ? -q : q;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int w;
        w = 0;
        s_axis_tdata  = {b, a};
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && w < 100) begin
            @(posedge aclk); #1;
            w++;
        end
        check("accept_ready", 16'(s_axis_tready), 16'd1);
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int lat;
        lat = 0;
        while (!m_axis_tvalid && lat < 100) begin
            @(posedge aclk); #1;
            lat++;
        end
        check({tag, "_latency"}, 16'(lat), 16'(AW + 2));
    endtask

    task automatic drain();
        m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        m_axis_tready = 1'b0;
        check("drain_m_tvalid", 16'(m_axis_tvalid), 16'd0);
        check("drain_s_tready", 16'(s_axis_tready), 16'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp);
        send(a, b);
        wait_valid(tag);
        check(tag, m_axis_tdata, exp);
        drain();
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_tready", 16'(s_axis_tready), 16'd0);
        check("rst_m_tvalid", 16'(m_axis_tvalid), 16'd0);
        check("rst_m_tdata",  m_axis_tdata, 16'd0);
        aresetn = 1'b1;
        check("rel_s_tready_still_low", 16'(s_axis_tready), 16'd0);
        @(posedge aclk); #1;
        check("idle_s_tready", 16'(s_axis_tready), 16'd1);

        // Basic rounding
        run_op("7/2",  16'd7,  16'd2, 16'd4);
        run_op("5/2",  16'd5,  16'd2, 16'd2);
        run_op("10/3", 16'd10, 16'd3, 16'd3);
        run_op("11/3", 16'd11, 16'd3, 16'd4);

        // Signs and ties
        run_op("-5/2",  16'(-5), 16'd2,   16'(-2));
        run_op("-7/2",  16'(-7), 16'd2,   16'(-4));
        run_op("7/-2",  16'd7,   16'(-2), 16'(-4));
        run_op("-9/-2", 16'(-9), 16'(-2), 16'd4);
        run_op("0/5",   16'd0,   16'd5,   16'd0);

        // Saturation and divide by zero
        run_op("-32768/-1", 16'h8000, 16'hffff, 16'h7fff);
        run_op("100/0",     16'd100,  16'd0,    16'h7fff);
        run_op("-100/0",    16'(-100), 16'd0,   16'h8000);
        run_op("0/0",       16'd0,    16'd0,    16'h7fff);
        run_op("-32768/1",  16'h8000, 16'd1,    16'h8000);

        // Backpressure: result held, a waiting operand is not consumed
        send(16'd7, 16'd2);
        wait_valid("bp_first");
        s_axis_tdata  = {16'd3, 16'd11};
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            check("bp_m_tdata",  m_axis_tdata, 16'd4);
            check("bp_m_tvalid", 16'(m_axis_tvalid), 16'd1);
            check("bp_s_tready", 16'(s_axis_tready), 16'd0);
        end
        m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        m_axis_tready = 1'b0;
        check("bp_release_m_tvalid", 16'(m_axis_tvalid), 16'd0);
        check("bp_release_s_tready", 16'(s_axis_tready), 16'd1);
        @(posedge aclk); #1;
        check("bp_next_accepted", 16'(s_axis_tready), 16'd0);
        s_axis_tvalid = 1'b0;
        wait_valid("bp_second");
        check("bp_second_result", m_axis_tdata, 16'd4);
        drain();

        // Reset in the middle of CALC
        send(16'd1000, 16'd3);
        repeat (5) @(posedge aclk);
        #1;
        check("calc_s_tready", 16'(s_axis_tready), 16'd0);
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_m_tvalid", 16'(m_axis_tvalid), 16'd0);
        check("midrst_m_tdata",  m_axis_tdata, 16'd0);
        check("midrst_s_tready", 16'(s_axis_tready), 16'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("postrst_m_tvalid", 16'(m_axis_tvalid), 16'd0);
        run_op("9/4", 16'd9, 16'd4, 16'd2);

        // Randomized streaming with random gaps and downstream stalls
        fork
            begin
                int          gap;
                int          sel;
                logic [15:0] ra;
                logic [15:0] rb;
                for (int i = 0; i < N_RAND; i++) begin
                    gap = int'($urandom_range(0, 2));
                    repeat (gap) begin
                        @(posedge aclk); #1;
                    end
                    ra  = 16'($urandom);
                    sel = int'($urandom_range(0, 7));
                    if (sel == 0)      rb = 16'd0;
                    else if (sel < 4)  rb = 16'($urandom_range(0, 16)) - 16'd8;
                    else               rb = 16'($urandom);
                    if (sel == 7)      ra = 16'h8000;
                    exp_q.push_back(ref_div(int'($signed(ra)), int'($signed(rb))));
                    send(ra, rb);
                end
            end
            begin
                int          got;
                int          cyc;
                logic        v;
                logic        r;
                logic [15:0] d;
                got = 0;
                cyc = 0;
                while (got < N_RAND && cyc < N_RAND * 40) begin
                    r = 1'($urandom);
                    m_axis_tready = r;
                    v = m_axis_tvalid;
                    d = m_axis_tdata;
                    @(posedge aclk); #1;
                    cyc++;
                    if (v && r) begin
                        if (exp_q.size() != 0) check("rand", d, exp_q.pop_front());
                        else                   check("rand_extra", 16'(v), 16'd0);
                        got++;
                    end
                end
                m_axis_tready = 1'b0;
                check("rand_count", 16'(got), 16'(N_RAND));
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
